// File: rtl/multi_deque_pkg.sv
// multi_deque_pkg: shared types and width helpers for the multi-channel deque.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package multi_deque_pkg;

  // Which end of a deque an operation applies to.
  typedef enum logic {
    END_BACK  = 1'b0,
    END_FRONT = 1'b1
  } end_e;

  // Pointer width for a channel of the given depth (depth is a power of two, >= 2).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: must be able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Channel select width: at least one bit even for a single channel.
  function automatic int sel_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/deque_channel.sv
// deque_channel: one double-ended circular buffer (mem, head, tail, cnt, optional hwm).
// Latency: state updates on the clock edge; peek/count/flags are combinational from state.
// Backpressure: none; illegal requests are dropped and flagged on rej (combinational).
// Ports: en gates all updates; push/pop with per-end selects; data_out peeks the
//   pop_front end (0 when empty); rej is raised for any rejected part of a request.
// Optional: MULTI_DEQUE_HWM_EN adds a high-water-mark register, else hwm reads 0.
module deque_channel
  import multi_deque_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      push,
  input  logic                      push_front,
  input  logic                      pop,
  input  logic                      pop_front,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      empty,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [cnt_w(DEPTH)-1:0]   hwm,
  output logic                      rej
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    cnt;

  logic [PW-1:0]    head_p1, head_m1, tail_p1, tail_m1;
  logic [PW-1:0]    head_nx, tail_nx, wr_addr;
  logic [CW-1:0]    cnt_nx;
  logic             wr_en;
  end_e             push_end, pop_end;

  assign push_end = end_e'(push_front);
  assign pop_end  = end_e'(pop_front);

  // Pointer arithmetic wraps naturally by truncation to PW bits.
  assign head_p1 = head + PW'(1);
  assign head_m1 = head - PW'(1);
  assign tail_p1 = tail + PW'(1);
  assign tail_m1 = tail - PW'(1);

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  // Empty channels peek as zero so stale memory never leaks out.
  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = (pop_end == END_FRONT) ? mem[head] : mem[tail_m1];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = tail;
    head_nx = head;
    tail_nx = tail;
    cnt_nx  = cnt;
    rej     = 1'b0;
    if (en) begin
      if (push && pop && !empty) begin
        wr_en = 1'b1;
        if (push_end == pop_end) begin
          // Replace the word sitting at that end; pointers stay put.
          wr_addr = (push_end == END_FRONT) ? head : tail_m1;
        end else if (push_end == END_FRONT) begin
          // Rotate: new word in front, back word dropped. Safe when full,
          // since head-1 is then the slot of the back word being popped.
          wr_addr = head_m1;
          head_nx = head_m1;
          tail_nx = tail_m1;
        end else begin
          wr_addr = tail;
          tail_nx = tail_p1;
          head_nx = head_p1;
        end
      end else if (push) begin
        if (full) begin
          rej = 1'b1;
        end else begin
          // A pop alongside a push here means the channel is empty: pop is dropped.
          rej   = pop;
          wr_en = 1'b1;
          if (push_end == END_FRONT) begin
            wr_addr = head_m1;
            head_nx = head_m1;
          end else begin
            wr_addr = tail;
            tail_nx = tail_p1;
          end
          cnt_nx = cnt + CW'(1);
        end
      end else if (pop) begin
        if (empty) begin
          rej = 1'b1;
        end else begin
          if (pop_end == END_FRONT) head_nx = head_p1;
          else                      tail_nx = tail_m1;
          cnt_nx = cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_nx;
      tail <= tail_nx;
      cnt  <= cnt_nx;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= data_in;
  end

`ifdef MULTI_DEQUE_HWM_EN
  logic [CW-1:0] hwm_q;
  always_ff @(posedge clk) begin
    if (!rst_n)              hwm_q <= '0;
    else if (cnt_nx > hwm_q) hwm_q <= cnt_nx;
  end
  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: rtl/multi_deque.sv
// multi_deque: CHANNELS independent deques, one addressed per cycle by sel.
// Latency: peek/count/hwm/flags combinational from state; err registered (next cycle).
// Backpressure: none; rejected or out-of-range requests are dropped and pulse err.
// Ports: clk, rst_n (sync, active-low), sel, push/push_front, pop/pop_front, data_in;
//   data_out/count/hwm for the selected channel, per-channel empty/full, err pulse.
// Optional: MULTI_DEQUE_HWM_EN enables per-channel high-water marks.
module multi_deque
  import multi_deque_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [sel_w(CHANNELS)-1:0]   sel,
  input  logic                         push,
  input  logic                         push_front,
  input  logic                         pop,
  input  logic                         pop_front,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
  output logic [CHANNELS-1:0]          empty,
  output logic [CHANNELS-1:0]          full,
  output logic [cnt_w(DEPTH)-1:0]      count,
  output logic                         err,
  output logic [cnt_w(DEPTH)-1:0]      hwm
);

  localparam int SW = sel_w(CHANNELS);
  localparam int CW = cnt_w(DEPTH);

  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] rej_ch;
  logic [WIDTH-1:0]    data_ch  [CHANNELS];
  logic [CW-1:0]       count_ch [CHANNELS];
  logic [CW-1:0]       hwm_ch   [CHANNELS];
  logic                err_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // An out-of-range sel matches no channel, so nothing updates.
    assign en[i] = (sel == SW'(i));

    deque_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[i]),
      .push       (push),
      .push_front (push_front),
      .pop        (pop),
      .pop_front  (pop_front),
      .data_in    (data_in),
      .data_out   (data_ch[i]),
      .empty      (empty[i]),
      .full       (full[i]),
      .count      (count_ch[i]),
      .hwm        (hwm_ch[i]),
      .rej        (rej_ch[i])
    );
  end

  always_comb begin
    data_out = '0;
    count    = '0;
    hwm      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (en[i]) begin
        data_out = data_ch[i];
        count    = count_ch[i];
        hwm      = hwm_ch[i];
      end
    end
  end

  // Channel rejects are already gated by en, so OR-ing them is safe.
  assign err_d = ((push || pop) && !(|en)) || (|rej_ch);

  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_d;
  end

endmodule
